// File: rtl/syscall_pkg.sv
// Shared constants for the execute-stage system-call unit: service codes,
// console output kinds, default decode ID and the controller state enum.
package syscall_pkg;

  localparam int unsigned SVC_PRINT_INT  = 1;
  localparam int unsigned SVC_EXIT       = 2;
  localparam int unsigned SVC_NOP        = 3;
  localparam int unsigned SVC_PRINT_CHR  = 4;
  localparam int unsigned SVC_READ_INT   = 5;

  localparam logic KIND_INT = 1'b0;
  localparam logic KIND_CHR = 1'b1;

  localparam int unsigned ID_SYSCALL_DEF = 26;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_IN = 2'd1,
    S_DONE    = 2'd2,
    S_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/syscall_fifo.sv
// Console output buffer: WIDTH bits wide, DEPTH (power of two) entries.
// Pushes into a full FIFO and pops from an empty one are ignored.
module syscall_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;
  assign o_rdata_c = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// Clocked system-call unit: buffered console output, exit/halt handling and
// an optional blocking integer read (enabled by defining SYSCALL_READ_EN).
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ID_SYSCALL = ID_SYSCALL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       ID,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] rd,
  output logic              stall,
  output logic              halted,
  output logic              bad_svc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_kind,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DATA_W-1:0] r_rd;
  logic            r_bad_svc;
  logic            w_bad_nxt;
  logic            w_rd_load;
  logic            w_req;
  logic            w_push;
  logic [DATA_W:0] w_push_word;
  logic [DATA_W:0] w_pop_word;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  assign w_req = valid_in && (ID == 32'(ID_SYSCALL));
  assign w_pop = out_ready && !w_empty;

  syscall_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_wdata   (w_push_word),
    .i_pop     (w_pop),
    .o_rdata_c (w_pop_word),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // State register plus registered read result and bad-service pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_bad_svc <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bad_svc <= w_bad_nxt;
      if (w_rd_load) r_rd <= in_data;
    end
  end

  // Next state, stall and FIFO push decode.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_push      = 1'b0;
    w_push_word = '0;
    w_bad_nxt   = 1'b0;
    w_rd_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          case (rs)
            DATA_W'(SVC_PRINT_INT): begin
              stall       = w_full;
              w_push      = !w_full;
              w_push_word = {KIND_INT, rt};
            end
            DATA_W'(SVC_PRINT_CHR): begin
              stall       = w_full;
              w_push      = !w_full;
              w_push_word = {KIND_CHR, DATA_W'(rt[7:0])};
            end
            DATA_W'(SVC_EXIT): begin
              stall = !w_empty;
              if (w_empty) w_state_nxt = S_HALT;
            end
            DATA_W'(SVC_NOP): begin
              stall = 1'b0;
            end
`ifdef SYSCALL_READ_EN
            DATA_W'(SVC_READ_INT): begin
              stall       = 1'b1;
              w_state_nxt = S_WAIT_IN;
            end
`endif
            default: begin
              w_bad_nxt = 1'b1;
            end
          endcase
        end
      end
`ifdef SYSCALL_READ_EN
      S_WAIT_IN: begin
        stall = 1'b1;
        if (in_valid) begin
          w_rd_load   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
`endif
      S_HALT: begin
        stall = w_req;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef SYSCALL_READ_EN
  assign in_ready = (r_state == S_WAIT_IN);
`else
  logic w_unused_in;
  assign w_unused_in = &{1'b0, in_valid, in_data};
  assign in_ready    = 1'b0;
`endif

  assign rd        = r_rd;
  assign bad_svc   = r_bad_svc;
  assign halted    = (r_state == S_HALT);
  assign out_valid = !w_empty;
  assign out_data  = w_pop_word[DATA_W-1:0];
  assign out_kind  = w_pop_word[DATA_W];

endmodule

// File: tb/tb_syscall_unit.sv
// Randomised and directed bench for syscall_unit against a queue-based model.
module tb_syscall_unit;

`ifdef SYSCALL_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] ID = '0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] rd;
  logic        stall;
  logic        halted;
  logic        bad_svc;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_kind;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue of expected {kind,data}, sticky halt, read progress, rd.
  logic [32:0] q[$];
  bit          m_halted = 0;
  bit          m_bad = 0;
  int          m_rphase = 0;  // 0 none, 1 waiting for input, 2 result delivered
  logic [31:0] m_rd = '0;

  syscall_unit #(.DATA_W(32), .FIFO_DEPTH(DEPTH), .ID_SYSCALL(26)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ID(ID), .rs(rs), .rt(rt),
    .rd(rd), .stall(stall), .halted(halted), .bad_svc(bad_svc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kind(out_kind), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model across posedge.
  task automatic step(output logic s);
    logic        req, exp_stall, acc, known, do_push, do_pop;
    logic [32:0] item;
    int          nphase;
    logic [31:0] nrd;
    @(negedge clk);
    req = valid_in && (ID == 32'd26);
    known = (rs >= 1 && rs <= 4) || (READ_EN && rs == 5);
    if (m_halted)           exp_stall = req;
    else if (m_rphase == 1) exp_stall = 1'b1;
    else if (m_rphase == 2) exp_stall = 1'b0;
    else if (!req)          exp_stall = 1'b0;
    else if (rs == 1 || rs == 4) exp_stall = (q.size() == DEPTH);
    else if (rs == 2)       exp_stall = (q.size() != 0);
    else if (rs == 5)       exp_stall = READ_EN;
    else                    exp_stall = 1'b0;
    check("stall", stall, exp_stall);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0][31:0]);
      check("out_kind", out_kind, q[0][32]);
    end
    check("halted", halted, m_halted);
    check("bad_svc", bad_svc, m_bad);
    check("in_ready", in_ready, m_rphase == 1);
    check("rd", rd, m_rd);
    acc     = req && !exp_stall && !m_halted && (m_rphase == 0);
    do_pop  = out_ready && (q.size() != 0);
    do_push = acc && (rs == 1 || rs == 4);
    item    = (rs == 4) ? {1'b1, 24'd0, rt[7:0]} : {1'b0, rt};
    nphase  = m_rphase;
    nrd     = m_rd;
    if (m_rphase == 0 && !m_halted && req && READ_EN && rs == 5) nphase = 1;
    else if (m_rphase == 1 && in_valid) begin nphase = 2; nrd = in_data; end
    else if (m_rphase == 2) nphase = 0;
    s = exp_stall;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(item);
    m_bad    = acc && !known;
    m_halted = m_halted || (acc && rs == 2);
    m_rphase = nphase;
    m_rd     = nrd;
  endtask

  // Present a request and hold it until the model says it was accepted.
  task automatic issue(input logic [31:0] svc, input logic [31:0] arg);
    logic s;
    valid_in = 1'b1; ID = 32'd26; rs = svc; rt = arg;
    s = 1'b1;
    for (int k = 0; k < 64 && s; k++) step(s);
    if (s) check("issue_timeout", 1, 0);
    valid_in = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_rd", rd, 0);
    check("rst_halted", halted, 0);
    check("rst_stall", stall, 0);
    check("rst_bad_svc", bad_svc, 0);
    q.delete(); m_halted = 0; m_bad = 0; m_rphase = 0; m_rd = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic s;
    #1;
    check("init_stall", stall, 0);
    check("init_out_valid", out_valid, 0);
    check("init_in_ready", in_ready, 0);
    check("init_rd", rd, 0);
    check("init_halted", halted, 0);
    check("init_bad_svc", bad_svc, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single print with ready drain.
    out_ready = 1'b1;
    issue(1, 32'd1001);
    repeat (2) step(s);

    // Fill to capacity, ninth print stalls until a slot frees.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) issue(1, 32'(i));
    valid_in = 1'b1; ID = 32'd26; rs = 1; rt = 32'd8;
    repeat (3) step(s);
    out_ready = 1'b1;
    issue(1, 32'd8);
    repeat (12) step(s);

    // Nop then unknown code.
    issue(3, 32'd0);
    issue(9, 32'd0);
    repeat (2) step(s);

    // Blocking read with input arriving after four waiting cycles.
    valid_in = 1'b1; ID = 32'd26; rs = 5; rt = 0; in_valid = 1'b0;
    repeat (5) step(s);
    in_valid = 1'b1; in_data = -32'sd7;
    step(s);
    in_valid = 1'b0;
    step(s);
    valid_in = 1'b0;
    repeat (2) step(s);

    // Random mix, no exit.
    s = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!s) begin
        valid_in = ($urandom_range(0, 3) != 0);
        ID = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'd26;
        case ($urandom_range(0, 7))
          0, 1:    rs = 1;
          2, 3:    rs = 4;
          4:       rs = 3;
          5:       rs = 5;
          6:       rs = 9;
          default: rs = 0;
        endcase
        rt = $urandom;
      end
      out_ready = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_data   = $urandom;
      step(s);
    end
    valid_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step(s);

    // Exit with three entries buffered, then requests stall forever.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(4, 32'h40 + 32'(i));
    out_ready = 1'b1;
    issue(2, 32'd0);
    step(s);
    valid_in = 1'b1; ID = 32'd26; rs = 1; rt = 32'd77;
    repeat (6) step(s);
    valid_in = 1'b0;
    pulse_reset();
    repeat (2) step(s);

    // Reset while a read waits with two entries buffered.
    out_ready = 1'b0; in_valid = 1'b0;
    issue(1, 32'd11);
    issue(4, 32'h41);
    valid_in = 1'b1; ID = 32'd26; rs = 5; rt = 0;
    repeat (2) step(s);
    valid_in = 1'b0;
    pulse_reset();
    repeat (3) step(s);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
